fft_butterfly_twiddle_stage: RTL

Pipelined complex twiddle-multiply stage of the floating-point FFT butterfly. It multiplies operand b by twiddle factor w and delays operand a by the same latency. The aligned pair (a, b·w) then goes directly into the butterfly add/subtract stage. Streaming: one butterfly input per cycle, no backpressure.

---
 rtl/fft_butterfly_twiddle_stage.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/fft_butterfly_twiddle_stage.sv
`default_nettype none
// ============================================================================
// Module   : fft_butterfly_twiddle_stage
// Brief    : Pipelined complex twiddle multiply (b*w) with matching a-delay,
//            feeding the butterfly add/sub stage. Optional macro
//            FFT_TWIDDLE_BYPASS_EN passes b through bit-exact when w_is_one.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef EXPONENT_BITS
`define EXPONENT_BITS 8
`endif
`ifndef SIGNIFICANT_BITS
`define SIGNIFICANT_BITS 23
`endif
`ifndef OVERALL_BITS
`define OVERALL_BITS 32
`endif

module fft_butterfly_twiddle_stage #(
    parameter int MUL_LATENCY = 3,
    parameter int ADD_LATENCY = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [`OVERALL_BITS-1:0] a_real,
    input  logic [`OVERALL_BITS-1:0] a_imag,
    input  logic [`OVERALL_BITS-1:0] b_real,
    input  logic [`OVERALL_BITS-1:0] b_imag,
    input  logic [`OVERALL_BITS-1:0] w_real,
    input  logic [`OVERALL_BITS-1:0] w_imag,
    input  logic                     w_is_one,
    output logic [`OVERALL_BITS-1:0] a_real_out,
    output logic [`OVERALL_BITS-1:0] a_imag_out,
    output logic [`OVERALL_BITS-1:0] bw_real,
    output logic [`OVERALL_BITS-1:0] bw_imag,
    output logic                     done,
    output logic                     busy
);

    localparam int c_e    = `EXPONENT_BITS;
    localparam int c_m    = `SIGNIFICANT_BITS;
    localparam int c_w    = `OVERALL_BITS;
    localparam int c_bias = (1 << (c_e - 1)) - 1;
    localparam int c_emax = (1 << c_e) - 1;
    localparam int c_lat  = MUL_LATENCY + ADD_LATENCY;
    localparam int c_cw   = $clog2(c_lat + 1);
    localparam logic [c_w-1:0] c_qnan = {1'b0, {c_e{1'b1}}, 1'b1, {(c_m-1){1'b0}}};

    if (MUL_LATENCY < 1 || ADD_LATENCY < 2) begin : g_bad_latency
        $error("fft_butterfly_twiddle_stage: MUL_LATENCY must be >= 1 and ADD_LATENCY >= 2");
    end
    if (c_w != 1 + c_e + c_m) begin : g_bad_format
        $error("fft_butterfly_twiddle_stage: OVERALL_BITS must equal 1+EXPONENT_BITS+SIGNIFICANT_BITS");
    end

    // Subnormal operands are treated as zero; results below the normal range flush to signed zero.
    function automatic logic [c_w-1:0] fp_mul(input logic [c_w-1:0] x, input logic [c_w-1:0] y);
        logic             s, x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
        logic [2*c_m+1:0] prod;
        logic [c_m+1:0]   mant;
        int               e;
        s      = x[c_w-1] ^ y[c_w-1];
        x_nan  = (&x[c_w-2:c_m]) && (|x[c_m-1:0]);
        y_nan  = (&y[c_w-2:c_m]) && (|y[c_m-1:0]);
        x_inf  = (&x[c_w-2:c_m]) && !(|x[c_m-1:0]);
        y_inf  = (&y[c_w-2:c_m]) && !(|y[c_m-1:0]);
        x_zero = ~|x[c_w-2:c_m];
        y_zero = ~|y[c_w-2:c_m];
        prod   = '0;
        mant   = '0;
        e      = 0;
        fp_mul = {s, {(c_w-1){1'b0}}};
        if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero)) begin
            fp_mul = c_qnan;
        end else if (x_inf || y_inf) begin
            fp_mul = {s, {c_e{1'b1}}, {c_m{1'b0}}};
        end else if (!x_zero && !y_zero) begin
            prod = (2*c_m+2)'({1'b1, x[c_m-1:0]}) * (2*c_m+2)'({1'b1, y[c_m-1:0]});
            e    = int'(x[c_w-2:c_m]) + int'(y[c_w-2:c_m]) - c_bias;
            if (prod[2*c_m+1]) e = e + 1;
            else               prod = prod << 1;
            // Round to nearest, ties to even
            mant = {1'b0, prod[2*c_m+1:c_m+1]}
                 + (c_m+2)'(prod[c_m] & ((|prod[c_m-1:0]) | prod[c_m+1]));
            if (mant[c_m+1]) begin
                mant = mant >> 1;
                e    = e + 1;
            end
            if (e >= c_emax)  fp_mul = {s, {c_e{1'b1}}, {c_m{1'b0}}};
            else if (e <= 0)  fp_mul = {s, {(c_w-1){1'b0}}};
            else              fp_mul = {s, e[c_e-1:0], mant[c_m-1:0]};
        end
    endfunction

    function automatic logic [c_w-1:0] fp_add(input logic [c_w-1:0] x, input logic [c_w-1:0] y);
        logic [c_w-1:0] big, sml;
        logic [c_m+3:0] mb, ms, mask;
        logic [c_m+4:0] sum;
        logic [c_m+1:0] mant;
        logic           x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, sticky;
        int             d, e;
        x_nan  = (&x[c_w-2:c_m]) && (|x[c_m-1:0]);
        y_nan  = (&y[c_w-2:c_m]) && (|y[c_m-1:0]);
        x_inf  = (&x[c_w-2:c_m]) && !(|x[c_m-1:0]);
        y_inf  = (&y[c_w-2:c_m]) && !(|y[c_m-1:0]);
        x_zero = ~|x[c_w-2:c_m];
        y_zero = ~|y[c_w-2:c_m];
        big    = x;
        sml    = y;
        mb     = '0;
        ms     = '0;
        mask   = '0;
        sum    = '0;
        mant   = '0;
        sticky = 1'b0;
        d      = 0;
        e      = 0;
        fp_add = '0;
        if (x_nan || y_nan || (x_inf && y_inf && (x[c_w-1] != y[c_w-1]))) begin
            fp_add = c_qnan;
        end else if (x_inf) begin
            fp_add = x;
        end else if (y_inf) begin
            fp_add = y;
        end else if (x_zero && y_zero) begin
            fp_add = {x[c_w-1] & y[c_w-1], {(c_w-1){1'b0}}};
        end else if (x_zero) begin
            fp_add = y;
        end else if (y_zero) begin
            fp_add = x;
        end else begin
            if (x[c_w-2:0] < y[c_w-2:0]) begin
                big = y;
                sml = x;
            end
            mb = {1'b1, big[c_m-1:0], 3'b000};
            ms = {1'b1, sml[c_m-1:0], 3'b000};
            e  = int'(big[c_w-2:c_m]);
            d  = e - int'(sml[c_w-2:c_m]);
            // Alignment: bits shifted out collapse into the sticky lsb
            if (d > c_m + 3) begin
                ms = {{(c_m+3){1'b0}}, 1'b1};
            end else begin
                mask   = ~({(c_m+4){1'b1}} << d);
                sticky = |(ms & mask);
                ms     = (ms >> d) | {{(c_m+3){1'b0}}, sticky};
            end
            if (big[c_w-1] == sml[c_w-1]) begin
                sum = {1'b0, mb} + {1'b0, ms};
                if (sum[c_m+4]) begin
                    sum = {1'b0, sum[c_m+4:1]} | {{(c_m+4){1'b0}}, sum[0]};
                    e   = e + 1;
                end
            end else begin
                sum = {1'b0, mb - ms};
                for (int i = 0; i < c_m + 4; i++) begin
                    if (!sum[c_m+3] && (sum != '0)) begin
                        sum = sum << 1;
                        e   = e - 1;
                    end
                end
            end
            if (sum == '0) begin
                fp_add = '0;
            end else begin
                mant = {1'b0, sum[c_m+3:3]} + (c_m+2)'(sum[2] & ((|sum[1:0]) | sum[3]));
                if (mant[c_m+1]) begin
                    mant = mant >> 1;
                    e    = e + 1;
                end
                if (e >= c_emax)  fp_add = {big[c_w-1], {c_e{1'b1}}, {c_m{1'b0}}};
                else if (e <= 0)  fp_add = {big[c_w-1], {(c_w-1){1'b0}}};
                else              fp_add = {big[c_w-1], e[c_e-1:0], mant[c_m-1:0]};
            end
        end
    endfunction

    logic [3:0][c_w-1:0] w_prod;
    logic [1:0][c_w-1:0] w_sum;
    logic [3:0][c_w-1:0] r_mul [MUL_LATENCY];
    logic [1:0][c_w-1:0] r_add [ADD_LATENCY-1];
    logic [1:0][c_w-1:0] r_a_dly [c_lat-1];
    logic [c_lat-1:0]    r_vld;
    logic [c_cw-1:0]     r_count;
    logic [c_w-1:0]      r_a_re, r_a_im, r_bw_re, r_bw_im;

    assign w_prod[0] = fp_mul(b_real, w_real);
    assign w_prod[1] = fp_mul(b_imag, w_imag);
    assign w_prod[2] = fp_mul(b_real, w_imag);
    assign w_prod[3] = fp_mul(b_imag, w_real);

    // Real part subtracts p1 by flipping its sign bit
    assign w_sum[0] = fp_add(r_mul[MUL_LATENCY-1][0],
                             {~r_mul[MUL_LATENCY-1][1][c_w-1], r_mul[MUL_LATENCY-1][1][c_w-2:0]});
    assign w_sum[1] = fp_add(r_mul[MUL_LATENCY-1][2], r_mul[MUL_LATENCY-1][3]);

`ifdef FFT_TWIDDLE_BYPASS_EN
    logic [1:0][c_w-1:0] r_b_dly [c_lat-1];
    logic [c_lat-2:0]    r_one;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_one <= '0;
            for (int i = 0; i < c_lat - 1; i++) r_b_dly[i] <= '0;
        end else begin
            r_one      <= {r_one[c_lat-3:0], w_is_one};
            r_b_dly[0] <= {b_imag, b_real};
            for (int i = 1; i < c_lat - 1; i++) r_b_dly[i] <= r_b_dly[i-1];
        end
    end
`else
    logic w_unused;
    assign w_unused = &{1'b0, w_is_one};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld   <= '0;
            r_count <= '0;
            r_a_re  <= '0;
            r_a_im  <= '0;
            r_bw_re <= '0;
            r_bw_im <= '0;
            for (int i = 0; i < MUL_LATENCY; i++)     r_mul[i]   <= '0;
            for (int i = 0; i < ADD_LATENCY - 1; i++) r_add[i]   <= '0;
            for (int i = 0; i < c_lat - 1; i++)       r_a_dly[i] <= '0;
        end else begin
            r_vld      <= {r_vld[c_lat-2:0], start};
            r_mul[0]   <= w_prod;
            r_add[0]   <= w_sum;
            r_a_dly[0] <= {a_imag, a_real};
            for (int i = 1; i < MUL_LATENCY; i++)     r_mul[i]   <= r_mul[i-1];
            for (int i = 1; i < ADD_LATENCY - 1; i++) r_add[i]   <= r_add[i-1];
            for (int i = 1; i < c_lat - 1; i++)       r_a_dly[i] <= r_a_dly[i-1];

            if (start && !r_vld[c_lat-1])      r_count <= r_count + c_cw'(1);
            else if (!start && r_vld[c_lat-1]) r_count <= r_count - c_cw'(1);

            // Output registers load only with a valid item and hold otherwise
            if (r_vld[c_lat-2]) begin
                r_a_re <= r_a_dly[c_lat-2][0];
                r_a_im <= r_a_dly[c_lat-2][1];
`ifdef FFT_TWIDDLE_BYPASS_EN
                if (r_one[c_lat-2]) begin
                    r_bw_re <= r_b_dly[c_lat-2][0];
                    r_bw_im <= r_b_dly[c_lat-2][1];
                end else begin
                    r_bw_re <= r_add[ADD_LATENCY-2][0];
                    r_bw_im <= r_add[ADD_LATENCY-2][1];
                end
`else
                r_bw_re <= r_add[ADD_LATENCY-2][0];
                r_bw_im <= r_add[ADD_LATENCY-2][1];
`endif
            end
        end
    end

    assign a_real_out = r_a_re;
    assign a_imag_out = r_a_im;
    assign bw_real    = r_bw_re;
    assign bw_imag    = r_bw_im;
    assign done       = r_vld[c_lat-1];
    assign busy       = (r_count != '0);

    a_count_overflow: assert property (@(posedge clk) disable iff (rst)
        !(r_count == c_cw'(c_lat) && start && !done));
    a_count_underflow: assert property (@(posedge clk) disable iff (rst)
        !(r_count == '0 && done && !start));

endmodule

`default_nettype wire
